// File: rtl/mmio_responder.sv
// mmio_responder
//   Memory-side bus target for the 8-bit multicycle processor. Addresses
//   below IO_BASE are RAM (not cleared by reset); from IO_BASE upward a small
//   register file exposes a synchronized switch port, an LED register and a
//   down-counting timer with a sticky expiry flag. Reads have one edge of
//   latency; q holds its value between reads.
//
//   I/O offsets from IO_BASE:
//     +0 SW_IN (ro)   +1 LED (rw)    +2 RELOAD (rw)
//     +3 COUNT (ro)   +4 CTRL (rw: bit0 EN, bit1 AUTO)
//     +5 STATUS (bit0 EXP, write 1 to clear)   others read 0
//
// Ports:
//   clock    in   rising-edge system clock
//   reset    in   asynchronous, active-high
//   MemRead  in   read strobe
//   wren     in   write strobe
//   address  in   [7:0] byte address
//   data     in   [7:0] write data
//   q        out  [7:0] registered read data
//   sw_in    in   [7:0] asynchronous switch inputs
//   led_out  out  [7:0] LED register
//   tmr_irq  out  timer expiry flag (STATUS bit0)
module mmio_responder #(
  parameter logic [7:0]  IO_BASE  = 8'hF0,
  parameter logic [15:0] PRESCALE = 16'd1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       MemRead,
  input  logic       wren,
  input  logic [7:0] address,
  input  logic [7:0] data,
  output logic [7:0] q,
  input  logic [7:0] sw_in,
  output logic [7:0] led_out,
  output logic       tmr_irq
);

  localparam int RAM_DEPTH = int'(IO_BASE);
  localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  localparam logic [7:0] OFF_SW     = 8'd0;
  localparam logic [7:0] OFF_LED    = 8'd1;
  localparam logic [7:0] OFF_RELOAD = 8'd2;
  localparam logic [7:0] OFF_COUNT  = 8'd3;
  localparam logic [7:0] OFF_CTRL   = 8'd4;
  localparam logic [7:0] OFF_STATUS = 8'd5;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic              is_ram;
  logic [7:0]        io_offset;
  logic [RAM_AW-1:0] ram_index;

  assign is_ram    = (address < IO_BASE);
  // Only meaningful when !is_ram, so the subtraction never wraps.
  assign io_offset = address - IO_BASE;
  assign ram_index = address[RAM_AW-1:0];

  logic led_wr, reload_wr, ctrl_wr, status_wr;
  assign led_wr    = wren && !is_ram && (io_offset == OFF_LED);
  assign reload_wr = wren && !is_ram && (io_offset == OFF_RELOAD);
  assign ctrl_wr   = wren && !is_ram && (io_offset == OFF_CTRL);
  assign status_wr = wren && !is_ram && (io_offset == OFF_STATUS);

  // ---------------------------------------------------------------------
  // RAM: no reset so it maps onto block RAM and survives a reset.
  // ---------------------------------------------------------------------
  logic [7:0] ram [0:RAM_DEPTH-1];
  logic [7:0] ram_rdata;

  always_ff @(posedge clock) begin
    if (wren && is_ram) begin
      ram[ram_index] <= data;
    end
  end

  assign ram_rdata = ram[ram_index];

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [7:0]  sw_sync1_reg, sw_sync2_reg;
  logic [7:0]  led_reg;
  logic [7:0]  reload_reg;
  logic [7:0]  count_reg, count_next;
  logic        en_reg, en_next;
  logic        auto_reg, auto_next;
  logic        exp_reg, exp_next;
  logic [15:0] prescale_reg, prescale_next;
  logic [7:0]  q_reg;
  logic [7:0]  rd_mux;

  // ---------------------------------------------------------------------
  // Timer next-state
  // ---------------------------------------------------------------------
  logic tick;
  logic start;
  logic exp_set;

  assign tick  = en_reg && (prescale_reg == (PRESCALE - 16'd1));
  assign start = ctrl_wr && !en_reg && data[0];

  always_comb begin
    count_next = count_reg;
    en_next    = en_reg;
    auto_next  = auto_reg;
    exp_set    = 1'b0;

    if (tick) begin
      if (count_reg != 8'd0) begin
        count_next = count_reg - 8'd1;
      end else begin
        exp_set = 1'b1;
        // reload_reg is the pre-edge value, so a RELOAD write in this
        // same cycle does not affect the auto-reload.
        if (auto_reg) begin
          count_next = reload_reg;
        end else begin
          en_next = 1'b0;
        end
      end
    end

    // A CTRL write overrides any timer-driven change to EN/AUTO.
    if (ctrl_wr) begin
      en_next   = data[0];
      auto_next = data[1];
      if (start) begin
        count_next = reload_reg;
      end
    end
  end

  // Prescaler is held at 0 whenever the timer is (or is about to be) idle,
  // and a fresh start always begins from 0.
  always_comb begin
    if (!en_reg || !en_next || tick) begin
      prescale_next = 16'd0;
    end else begin
      prescale_next = prescale_reg + 16'd1;
    end
  end

  // Set beats a simultaneous write-1-to-clear.
  always_comb begin
    exp_next = exp_reg;
    if (status_wr && data[0]) begin
      exp_next = 1'b0;
    end
    if (exp_set) begin
      exp_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Read mux (pre-edge values, so read-during-write returns old data)
  // ---------------------------------------------------------------------
  always_comb begin
    rd_mux = 8'h00;
    if (is_ram) begin
      rd_mux = ram_rdata;
    end else begin
      case (io_offset)
        OFF_SW:     rd_mux = sw_sync2_reg;
        OFF_LED:    rd_mux = led_reg;
        OFF_RELOAD: rd_mux = reload_reg;
        OFF_COUNT:  rd_mux = count_reg;
        OFF_CTRL:   rd_mux = {6'b0, auto_reg, en_reg};
        OFF_STATUS: rd_mux = {7'b0, exp_reg};
        default:    rd_mux = 8'h00;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_sync1_reg <= 8'h00;
      sw_sync2_reg <= 8'h00;
      led_reg      <= 8'h00;
      reload_reg   <= 8'h00;
      count_reg    <= 8'h00;
      en_reg       <= 1'b0;
      auto_reg     <= 1'b0;
      exp_reg      <= 1'b0;
      prescale_reg <= 16'd0;
      q_reg        <= 8'h00;
    end else begin
      sw_sync1_reg <= sw_in;
      sw_sync2_reg <= sw_sync1_reg;
      if (led_wr) begin
        led_reg <= data;
      end
      if (reload_wr) begin
        reload_reg <= data;
      end
      count_reg    <= count_next;
      en_reg       <= en_next;
      auto_reg     <= auto_next;
      exp_reg      <= exp_next;
      prescale_reg <= prescale_next;
      if (MemRead) begin
        q_reg <= rd_mux;
      end
    end
  end

  assign q       = q_reg;
  assign led_out = led_reg;
  assign tmr_irq = exp_reg;

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-side bus target for the 8-bit multicycle processor. It answers the processor's `MemRead`/`wren` accesses with a synchronous, one-cycle-latency read port. Below `IO_BASE` it holds RAM; from `IO_BASE` up it exposes memory-mapped I/O: a switch input port, an LED output register, and a down-counting timer with a sticky expiry flag. It drops in where the processor's data memory sits today, on the same address, data and `q` wires.

## Interface
Parameters:
- `IO_BASE`, default 8'hF0: first I/O address. Addresses below it are RAM.
- `PRESCALE`, default 16'd1: timer tick period in clock cycles, range 1..65535.

Ports:
- `clock`  in  1: system clock, rising-edge.
- `reset`  in  1: asynchronous, active-high.
- `MemRead`  in  1: read strobe, sampled at the rising edge.
- `wren`  in  1: write strobe, sampled at the rising edge.
- `address`  in  8: byte address.
- `data`  in  8: write data.
- `q`  out  8: registered read data.
- `sw_in`  in  8: asynchronous switch inputs.
- `led_out`  out  8: LED register contents.
- `tmr_irq`  out  1: equals STATUS bit0.

## Operation
- **RAM:** `IO_BASE` bytes, addresses 0..`IO_BASE`-1. Contents are not cleared by reset.
- **Read:** at each edge with `MemRead`=1, `q` <= the value at `address` before that edge's updates. With `MemRead`=0, `q` holds.
- **Write:** at each edge with `wren`=1, the target is updated. If both strobes are set, the read returns the old data and the write still takes effect.
- **I/O map** (offsets from `IO_BASE`):
  - +0 SW_IN: read-only. Returns `sw_in` after a 2-flop synchronizer.
  - +1 LED: read/write. Drives `led_out`.
  - +2 RELOAD: read/write. Timer reload value.
  - +3 COUNT: read-only. Current timer value.
  - +4 CTRL: read/write. bit0 = EN, bit1 = AUTO; bits 7:2 read 0.
  - +5 STATUS: bit0 = EXP, sticky. Writing 1 to bit0 clears it; writing 0 has no effect. Bits 7:1 read 0.
  - +6 to +0x0F, and anything that wraps past 0xFF: reads return 0, writes are ignored.
- **Timer start:** a CTRL write that takes EN from 0 to 1 loads COUNT <= RELOAD and clears the prescaler.
  - A CTRL write with EN=1 while the timer is already enabled does not reload.
- **Prescaler:** counts 0..`PRESCALE`-1 while EN=1. A tick occurs on the cycle it wraps. It is held at 0 while EN=0.
- **On each tick:**
  - If COUNT != 0: COUNT <= COUNT-1.
  - If COUNT == 0: EXP <= 1. Then, if AUTO=1, COUNT <= RELOAD and EN stays 1. If AUTO=0, EN <= 0 and COUNT stays 0.
- **RELOAD = 0 with AUTO = 1:** EXP asserts on every tick.
- **Simultaneous events:**
  - EXP set and a W1C in the same cycle: the set wins, so EXP=1.
  - Timer-driven EN clear and a CTRL write in the same cycle: the CTRL write wins.
  - A RELOAD write in the same cycle as an auto-reload: the old RELOAD value is used.
- **Arithmetic:** all arithmetic is 8-bit unsigned. COUNT never wraps below 0.

## Timing
- **Reset values:** `q`=0, `led_out`=0, `tmr_irq`=0. LED, RELOAD, COUNT, CTRL, STATUS, the prescaler and the synchronizer are all 0.
- **Read latency:** one edge. The address is presented with `MemRead` in cycle n, and `q` is valid after edge n until the next read edge.
- **Write visibility:** a write at edge n is visible to a read at edge n+1. `led_out` updates at edge n.
- **SW_IN latency:** 2 edges from a `sw_in` change to a readable value. It is visible on `q` one edge later.
- **Timer expiry timing:** with `PRESCALE`=P, RELOAD=R and EN set at edge e, EXP rises at edge e + P·(R+1).
- **`tmr_irq`:** follows EXP combinationally from the register, so it adds no cycle of latency.
- **Reset mid-operation:** `reset` asserted asynchronously forces all reset values immediately, including mid-countdown. After release, the timer stays idle until EN is written again.

## Test plan
- **RAM:** write 0x5A to 0x10, then read 0x10 on the next edge -> `q`=0x5A one edge later. Read and write 0x10 with 0xA5 at the same edge -> `q`=0x5A, and a subsequent read gives 0xA5.
- **LED and SW_IN:** write 0x3C to 0xF1 -> `led_out`=0x3C the same edge. Set `sw_in`=0x81, wait 2 edges, read 0xF0 -> `q`=0x81.
- **One-shot timer:** `PRESCALE`=1, RELOAD=3, write CTRL=0x01 -> COUNT reads 3,2,1,0 on successive cycles. `tmr_irq` rises 4 edges after the CTRL write, EN reads 0, and COUNT stays 0.
- **Auto-reload:** RELOAD=2, CTRL=0x03 -> `tmr_irq` rises after 3 edges. Writing 0x01 to 0xF5 clears it. It is set again 3 ticks later. Issuing the W1C on the expiry edge leaves it set.
- **Holes and reset:** read 0xF8 -> 0, and a write to 0xF8 changes nothing. Assert `reset` mid-countdown -> COUNT, CTRL, `led_out`, `q` and `tmr_irq` are all 0 immediately, and the earlier RAM data at 0x10 is retained.
